lvds_rx_framer: RTL and testbench

- Parametrised successor to the LVDS DDR I/Q receiver.
- Deserialises a DATA_W-bit-per-clock stream into framed I/Q words. Each frame is 2*PHASE_BITS bits, and the I phase and Q phase each start with a sync symbol.
- Adds beyond the previous generation: configurable lane/phase widths and sync symbols, frame-lock qualification, immediate resync on a sync-start symbol, and saturating error/drop counters.
- Sits between the LVDS pad DDR capture and the RX async FIFO, in the i_ddr_clk domain.

---
 rtl/lvds_rx_pkg.sv | 20 ++
 rtl/sat_counter.sv | 29 ++
 rtl/lvds_rx_framer.sv | 184 ++++++++++++++++++
 tb/tb_lvds_rx_framer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_rx_pkg.sv
// rtl/lvds_rx_pkg.sv - shared types and constants for the LVDS I/Q receive framer
package lvds_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_I_PHASE = 2'b01,
        ST_Q_PHASE = 2'b11
    } rx_state_e;

    localparam logic [1:0] SYNC_I_DEFAULT = 2'b10;
    localparam logic [1:0] SYNC_Q_DEFAULT = 2'b01;

    // Wide enough for any lock qualification target in 0..255.
    localparam int LOCK_CNT_W = 8;

    function automatic int beats_per_phase(input int phase_bits, input int data_w);
        return phase_bits / data_w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/lvds_rx_framer.sv
// rtl/lvds_rx_framer.sv - frames a deserialised LVDS lane into I/Q words for the RX FIFO
module lvds_rx_framer
    import lvds_rx_pkg::*;
#(
    parameter int                DATA_W      = 2,
    parameter int                PHASE_BITS  = 16,
    parameter logic [DATA_W-1:0] SYNC_I      = SYNC_I_DEFAULT,
    parameter logic [DATA_W-1:0] SYNC_Q      = SYNC_Q_DEFAULT,
    parameter int                LOCK_FRAMES = 2,
    parameter int                CNT_W       = 16
) (
    input  logic                    i_ddr_clk,
    input  logic                    i_reset_n,
    input  logic [DATA_W-1:0]       i_ddr_data,
    input  logic                    i_enable,
    input  logic                    i_fifo_full,
    output logic                    o_fifo_write_clk,
    output logic                    o_fifo_push,
    output logic [2*PHASE_BITS-1:0] o_fifo_data,
    output logic                    o_locked,
    output logic [CNT_W-1:0]        o_sync_err_cnt,
    output logic [CNT_W-1:0]        o_drop_cnt,
    output logic [1:0]              o_debug_state
);

    localparam int N       = beats_per_phase(PHASE_BITS, DATA_W);
    localparam int FRAME_W = 2 * PHASE_BITS;
    localparam int SHIFT_W = FRAME_W - DATA_W;
    localparam int BEAT_W  = $clog2(2 * N);

    localparam logic [BEAT_W-1:0]     LAST_I      = BEAT_W'(N - 1);
    localparam logic [BEAT_W-1:0]     FIRST_Q     = BEAT_W'(N);
    localparam logic [BEAT_W-1:0]     LAST_Q      = BEAT_W'(2 * N - 1);
    localparam logic [LOCK_CNT_W-1:0] LOCK_TARGET = LOCK_CNT_W'(LOCK_FRAMES);

    // With a single beat per phase the sync-I beat is the whole I phase.
    localparam rx_state_e START_STATE = (N == 1) ? ST_Q_PHASE : ST_I_PHASE;

    rx_state_e             state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  locked_q, locked_d;
    logic                  push_q, push_d;
    logic [FRAME_W-1:0]    data_q, data_d;

    logic [FRAME_W-1:0]    frame_word;
    logic                  frame_done;
    logic                  sync_err;
    logic                  drop_inc;

    // Only FRAME_W-DATA_W bits are stored; the last beat is appended live.
    assign frame_word = {shift_q, i_ddr_data};

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        sync_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_ddr_data == SYNC_I) begin
                    shift_d = SHIFT_W'(i_ddr_data);
                    beat_d  = BEAT_W'(1);
                    state_d = START_STATE;
                end
            end
            ST_I_PHASE: begin
                shift_d = frame_word[SHIFT_W-1:0];
                beat_d  = beat_q + BEAT_W'(1);
                if (beat_q == LAST_I) begin
                    state_d = ST_Q_PHASE;
                end
            end
            ST_Q_PHASE: begin
                if ((beat_q == FIRST_Q) && (i_ddr_data != SYNC_Q)) begin
                    sync_err = 1'b1;
                    if (i_ddr_data == SYNC_I) begin
                        shift_d = SHIFT_W'(i_ddr_data);
                        beat_d  = BEAT_W'(1);
                        state_d = START_STATE;
                    end else begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    shift_d = frame_word[SHIFT_W-1:0];
                    if (beat_q == LAST_Q) begin
                        frame_done = 1'b1;
                        beat_d     = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                beat_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        push_d     = 1'b0;
        data_d     = data_q;
        drop_inc   = 1'b0;

        if (frame_done) begin
            if (!locked_q) begin
                lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                if (lock_cnt_d == LOCK_TARGET) begin
                    locked_d = 1'b1;
                end
            end else if (i_enable) begin
                if (!i_fifo_full) begin
                    push_d = 1'b1;
                    data_d = frame_word;
                end else begin
                    drop_inc = 1'b1;
                end
            end
        end

        if (LOCK_FRAMES == 0) begin
            locked_d = 1'b1;
        end

        // A bad Q sync always wins over qualification, even with no target.
        if (sync_err) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end
    end

    always_ff @(posedge i_ddr_clk) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            shift_q    <= '0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            push_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            shift_q    <= shift_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            push_q     <= push_d;
            data_q     <= data_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_sync_err_cnt (
        .clk  (i_ddr_clk),
        .clr  (~i_reset_n),
        .inc  (sync_err),
        .count(o_sync_err_cnt)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_drop_cnt (
        .clk  (i_ddr_clk),
        .clr  (~i_reset_n),
        .inc  (drop_inc),
        .count(o_drop_cnt)
    );

    assign o_fifo_write_clk = i_ddr_clk;
    assign o_fifo_push      = push_q;
    assign o_fifo_data      = data_q;
    assign o_locked         = locked_q;
    assign o_debug_state    = state_q;

endmodule

// File: tb/tb_lvds_rx_framer.sv
// tb/tb_lvds_rx_framer.sv - self-checking bench for lvds_rx_framer
module tb_lvds_rx_framer;

    localparam int N  = 8;
    localparam int LF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ddr = 2'b00;
    logic        enable = 1'b1;
    logic        fifo_full = 1'b0;

    logic        d_wclk, d_push, d_locked;
    logic [31:0] d_data;
    logic [15:0] d_err, d_drop;
    logic [1:0]  d_state;

    logic        s_wclk, s_push, s_locked;
    logic [31:0] s_data;
    logic [3:0]  s_err, s_drop;
    logic [1:0]  s_state;

    always #5 clk = ~clk;

    lvds_rx_framer dut (
        .i_ddr_clk(clk), .i_reset_n(rst_n), .i_ddr_data(ddr), .i_enable(enable),
        .i_fifo_full(fifo_full), .o_fifo_write_clk(d_wclk), .o_fifo_push(d_push),
        .o_fifo_data(d_data), .o_locked(d_locked), .o_sync_err_cnt(d_err),
        .o_drop_cnt(d_drop), .o_debug_state(d_state)
    );

    lvds_rx_framer #(.CNT_W(4)) dut_s (
        .i_ddr_clk(clk), .i_reset_n(rst_n), .i_ddr_data(ddr), .i_enable(enable),
        .i_fifo_full(fifo_full), .o_fifo_write_clk(s_wclk), .o_fifo_push(s_push),
        .o_fifo_data(s_data), .o_locked(s_locked), .o_sync_err_cnt(s_err),
        .o_drop_cnt(s_drop), .o_debug_state(s_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position of the next expected beat (-1 = hunting).
    int          m_pos = -1;
    longint      m_acc = 0;
    int          m_lockcnt = 0;
    bit          m_locked = 0;
    int          m_err = 0;
    int          m_drop = 0;
    bit          m_push = 0;
    logic [31:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic model(input logic [1:0] d, input logic full, input logic en, input logic rn);
        bit done;
        bit err;
        done = 0;
        err  = 0;
        if (!rn) begin
            m_pos = -1; m_acc = 0; m_lockcnt = 0; m_locked = 0;
            m_err = 0; m_drop = 0; m_push = 0; m_data = '0;
            return;
        end
        m_push = 0;
        if (m_pos < 0) begin
            if (d == 2'b10) begin m_acc = d; m_pos = 1; end
        end else if (m_pos == N && d != 2'b01) begin
            err = 1;
            m_err++;
            if (d == 2'b10) begin m_acc = d; m_pos = 1; end
            else m_pos = -1;
        end else begin
            m_acc = (m_acc * 4 + d) % 64'h1_0000_0000;
            if (m_pos == 2 * N - 1) begin done = 1; m_pos = -1; end
            else m_pos++;
        end
        if (done) begin
            if (!m_locked) begin
                m_lockcnt++;
                if (m_lockcnt >= LF) m_locked = 1;
            end else if (en) begin
                if (!full) begin m_push = 1; m_data = 32'(m_acc); end
                else m_drop++;
            end
        end
        if (err) begin m_lockcnt = 0; m_locked = 0; end
    endtask

    task automatic compare_all();
        logic [1:0] st;
        st = (m_pos < 0) ? 2'b00 : ((m_pos < N) ? 2'b01 : 2'b11);
        chk("push",   {31'd0, d_push},   {31'd0, m_push});
        chk("data",   d_data,            m_data);
        chk("locked", {31'd0, d_locked}, {31'd0, m_locked});
        chk("state",  {30'd0, d_state},  {30'd0, st});
        chk("errcnt", {16'd0, d_err},    32'(sat(m_err, 65535)));
        chk("dropcnt",{16'd0, d_drop},   32'(sat(m_drop, 65535)));
        chk("s_push", {31'd0, s_push},   {31'd0, m_push});
        chk("s_errcnt",  {28'd0, s_err},  32'(sat(m_err, 15)));
        chk("s_dropcnt", {28'd0, s_drop}, 32'(sat(m_drop, 15)));
        chk("wclk",   {31'd0, d_wclk},   32'd0);
    endtask

    task automatic step(input logic [1:0] d, input logic full, input logic en);
        ddr = d;
        fifo_full = full;
        enable = en;
        @(posedge clk);
        model(d, full, en, rst_n);
        @(negedge clk);
        compare_all();
    endtask

    // fifo_full is randomised on every beat except the last, where it matters.
    task automatic send_beats(input logic [31:0] f, input int first, input int last,
                              input logic full, input logic en);
        for (int b = first; b <= last; b++) begin
            step(f[31-2*b -: 2], (b == 15) ? full : 1'($urandom), en);
        end
    endtask

    task automatic send_frame(input logic [15:0] iw, input logic [15:0] qw,
                              input logic full, input logic en);
        send_beats({iw, qw}, 0, 15, full, en);
    endtask

    typedef struct {
        logic [15:0] i_w;
        logic [15:0] q_w;
        logic        full;
        logic        en;
        logic        exp_push;
        logic [31:0] exp_data;
        logic        exp_locked;
    } frame_vec_t;

    frame_vec_t tbl[6];

    initial begin
        tbl[0] = '{16'h8ABC, 16'h4123, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        tbl[1] = '{16'h8ABC, 16'h4123, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        tbl[2] = '{16'h8ABC, 16'h4123, 1'b0, 1'b1, 1'b1, 32'h8ABC_4123, 1'b1};
        tbl[3] = '{16'hB00F, 16'h7FF0, 1'b1, 1'b1, 1'b0, 32'h8ABC_4123, 1'b1};
        tbl[4] = '{16'h9234, 16'h5678, 1'b0, 1'b1, 1'b1, 32'h9234_5678, 1'b1};
        tbl[5] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 1'b0, 32'h9234_5678, 1'b1};

        rst_n = 1'b0;
        step(2'b10, 1'b0, 1'b1);
        step(2'b10, 1'b0, 1'b1);
        chk("rst_push",   {31'd0, d_push},   32'd0);
        chk("rst_data",   d_data,            32'd0);
        chk("rst_locked", {31'd0, d_locked}, 32'd0);
        chk("rst_state",  {30'd0, d_state},  32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].i_w, tbl[i].q_w, tbl[i].full, tbl[i].en);
            chk($sformatf("tbl%0d_push", i),   {31'd0, d_push},   {31'd0, tbl[i].exp_push});
            chk($sformatf("tbl%0d_data", i),   d_data,            tbl[i].exp_data);
            chk($sformatf("tbl%0d_locked", i), {31'd0, d_locked}, {31'd0, tbl[i].exp_locked});
        end
        step(2'b00, 1'b0, 1'b1);
        chk("push_single_cycle", {31'd0, d_push}, 32'd0);
        chk("drop_after_full",   {16'd0, d_drop}, 32'd1);

        // Q-sync error while locked, then re-lock with no pushes.
        send_beats({16'h8ABC, 16'h4123}, 0, 7, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b1);
        chk("qerr_cnt",    {16'd0, d_err},    32'd1);
        chk("qerr_locked", {31'd0, d_locked}, 32'd0);
        chk("qerr_state",  {30'd0, d_state},  32'd0);
        step(2'b00, 1'b0, 1'b1);
        send_frame(16'h8ABC, 16'h4123, 1'b0, 1'b1);
        chk("relock1_push",   {31'd0, d_push},   32'd0);
        chk("relock1_locked", {31'd0, d_locked}, 32'd0);
        send_frame(16'h8ABC, 16'h4123, 1'b0, 1'b1);
        chk("relock2_push",   {31'd0, d_push},   32'd0);
        chk("relock2_locked", {31'd0, d_locked}, 32'd1);

        // Resync: error beat is SYNC_I and begins a new frame.
        send_beats({16'h8ABC, 16'h4123}, 0, 7, 1'b0, 1'b1);
        step(2'b10, 1'b0, 1'b1);
        chk("resync_cnt",   {16'd0, d_err},   32'd2);
        chk("resync_state", {30'd0, d_state}, 32'd1);
        send_beats({16'h8123, 16'h4567}, 1, 15, 1'b0, 1'b1);
        chk("resync_done_state", {30'd0, d_state}, 32'd0);
        send_frame(16'h9999, 16'h4444, 1'b0, 1'b1);
        chk("resync_locked", {31'd0, d_locked}, 32'd1);

        // Saturation of the 4-bit counter.
        for (int k = 0; k < 20; k++) begin
            send_beats({16'h8ABC, 16'h4123}, 0, 7, 1'b0, 1'b1);
            step(2'b11, 1'b0, 1'b1);
        end
        chk("sat_s_err", {28'd0, s_err}, 32'hF);
        chk("sat_d_err", {16'd0, d_err}, 32'd22);
        send_beats({16'h8ABC, 16'h4123}, 0, 7, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
        chk("sat_s_err_hold", {28'd0, s_err}, 32'hF);

        // Reset mid-frame of a locked stream.
        send_frame(16'h8ABC, 16'h4123, 1'b0, 1'b1);
        send_frame(16'h8ABC, 16'h4123, 1'b0, 1'b1);
        send_frame(16'hA001, 16'h6002, 1'b0, 1'b1);
        chk("prereset_push", {31'd0, d_push}, 32'd1);
        send_beats({16'h8ABC, 16'h4123}, 0, 4, 1'b0, 1'b1);
        rst_n = 1'b0;
        step(2'b11, 1'b0, 1'b1);
        chk("midrst_push",   {31'd0, d_push},   32'd0);
        chk("midrst_data",   d_data,            32'd0);
        chk("midrst_locked", {31'd0, d_locked}, 32'd0);
        chk("midrst_err",    {16'd0, d_err},    32'd0);
        chk("midrst_state",  {30'd0, d_state},  32'd0);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int f = 0; f < 300; f++) begin
            int kind;
            logic [15:0] iw, qw;
            kind = $urandom_range(0, 19);
            iw = {2'b10, 14'($urandom)};
            qw = {2'b01, 14'($urandom)};
            if (kind < 14) begin
                send_frame(iw, qw, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
            end else if (kind < 17) begin
                logic [1:0] bad;
                bad = 2'($urandom_range(0, 2));
                if (bad == 2'b01) bad = 2'b11;
                qw[15:14] = bad;
                send_frame(iw, qw, 1'b0, 1'b1);
            end else if (kind < 19) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                    step(2'($urandom), 1'($urandom), 1'b1);
            end else begin
                rst_n = 1'b0;
                step(2'($urandom), 1'b0, 1'b1);
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
